// File: rtl/ddr_channel_arbiter.sv
// Fixed-priority (store > load > fetch) front end that serialises three core channels onto one DDR request bus.
// Optional watchdog on the WAIT state is compiled in with `define DDR_ARB_TIMEOUT_EN.
module ddr_channel_arbiter #(
   parameter int INDEX_W        = 19,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pc_req,
   input  logic [INDEX_W-1:0] pc_index,
   output logic               pc_done,
   output logic [511:0]       pc_rdata,
   input  logic               opload_req,
   input  logic [INDEX_W-1:0] opload_index,
   output logic               opload_done,
   output logic [63:0]        opload_rdata,
   input  logic               opstore_req,
   input  logic [INDEX_W-1:0] opstore_index,
   input  logic [63:0]        opstore_wmask,
   input  logic [63:0]        opstore_wdata,
   output logic               opstore_done,
   output logic               ddr_chip_enable,
   output logic [INDEX_W-1:0] ddr_index,
   output logic               ddr_write_enable,
   output logic               ddr_burst_mode,
   output logic [63:0]        ddr_opstore_write_mask,
   output logic [63:0]        ddr_opstore_write_data,
   input  logic [63:0]        ddr_opload_read_data,
   input  logic [511:0]       ddr_pc_read_inst,
   input  logic               ddr_operation_done,
   input  logic               ddr_ready,
   output logic               busy,
   output logic               timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {G_NONE, G_STORE, G_LOAD, G_PC} grant_t;

   state_t             state, state_next;
   grant_t             grant, grant_next;
   logic [INDEX_W-1:0] issue_index;
   logic [63:0]        issue_mask, issue_data;
   logic               capture, enter_resp, timeout_hit;

`ifdef DDR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT) && !ddr_operation_done &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ISSUE)
            wait_cnt <= '0;
         else if (state == WAIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (timeout_hit)
            timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   // Constant 0: the watchdog is compiled out, so the limit can never be reached.
   assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         grant <= G_NONE;
      end else begin
         state <= state_next;
         grant <= grant_next;
      end
   end

   always_comb begin
      state_next  = state;
      grant_next  = grant;
      issue_index = '0;
      issue_mask  = '0;
      issue_data  = '0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (ddr_ready) begin
               if (opstore_req) begin
                  grant_next  = G_STORE;
                  issue_index = opstore_index;
                  issue_mask  = opstore_wmask;
                  issue_data  = opstore_wdata;
                  state_next  = ISSUE;
               end else if (opload_req) begin
                  grant_next  = G_LOAD;
                  issue_index = opload_index;
                  state_next  = ISSUE;
               end else if (pc_req) begin
                  grant_next  = G_PC;
                  issue_index = pc_index;
                  state_next  = ISSUE;
               end
            end
         end
         // Responder cannot answer in the strobe cycle, so done is not looked at here.
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (ddr_operation_done) begin
               capture    = 1'b1;
               state_next = RESP;
            end else if (timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_resp = (state == WAIT) && (state_next == RESP);

   always_ff @(posedge clock) begin
      if (reset) begin
         ddr_chip_enable        <= 1'b0;
         busy                   <= 1'b0;
         pc_done                <= 1'b0;
         opload_done            <= 1'b0;
         opstore_done           <= 1'b0;
         ddr_index              <= '0;
         ddr_write_enable       <= 1'b0;
         ddr_burst_mode         <= 1'b0;
         ddr_opstore_write_mask <= '0;
         ddr_opstore_write_data <= '0;
         pc_rdata               <= '0;
         opload_rdata           <= '0;
      end else begin
         ddr_chip_enable <= (state_next == ISSUE);
         busy            <= (state_next != IDLE);
         opstore_done    <= enter_resp && (grant == G_STORE);
         opload_done     <= enter_resp && (grant == G_LOAD);
         pc_done         <= enter_resp && (grant == G_PC);
         // Request fields stay frozen from the strobe until the next grant.
         if (state == IDLE && state_next == ISSUE) begin
            ddr_index              <= issue_index;
            ddr_write_enable       <= (grant_next == G_STORE);
            ddr_burst_mode         <= (grant_next == G_PC);
            ddr_opstore_write_mask <= issue_mask;
            ddr_opstore_write_data <= issue_data;
         end
         if (capture && grant == G_PC)
            pc_rdata <= ddr_pc_read_inst;
         if (capture && grant == G_LOAD)
            opload_rdata <= ddr_opload_read_data;
      end
   end

endmodule

// File: tb/tb_ddr_channel_arbiter.sv
// Directed bench for ddr_channel_arbiter: a transaction-level model checked every cycle plus literal checks per scenario.
module tb_ddr_channel_arbiter;
   localparam int IW  = 19;
   localparam int TMO = 8;

   logic          clock;
   logic          reset;
   logic          pc_req, opload_req, opstore_req;
   logic [IW-1:0] pc_index, opload_index, opstore_index;
   logic [63:0]   opstore_wmask, opstore_wdata;
   logic          pc_done, opload_done, opstore_done;
   logic [511:0]  pc_rdata;
   logic [63:0]   opload_rdata;
   logic          ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
   logic [IW-1:0] ddr_index;
   logic [63:0]   ddr_opstore_write_mask, ddr_opstore_write_data;
   logic [63:0]   ddr_opload_read_data;
   logic [511:0]  ddr_pc_read_inst;
   logic          ddr_operation_done, ddr_ready;
   logic          busy, timeout_err;

   ddr_channel_arbiter #(.INDEX_W(IW), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset),
      .pc_req(pc_req), .pc_index(pc_index), .pc_done(pc_done), .pc_rdata(pc_rdata),
      .opload_req(opload_req), .opload_index(opload_index), .opload_done(opload_done),
      .opload_rdata(opload_rdata),
      .opstore_req(opstore_req), .opstore_index(opstore_index), .opstore_wmask(opstore_wmask),
      .opstore_wdata(opstore_wdata), .opstore_done(opstore_done),
      .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable),
      .ddr_burst_mode(ddr_burst_mode), .ddr_opstore_write_mask(ddr_opstore_write_mask),
      .ddr_opstore_write_data(ddr_opstore_write_data), .ddr_opload_read_data(ddr_opload_read_data),
      .ddr_pc_read_inst(ddr_pc_read_inst), .ddr_operation_done(ddr_operation_done),
      .ddr_ready(ddr_ready), .busy(busy), .timeout_err(timeout_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_assert = 0, n_fail = 0, cyc = 0;
   int n_strobe = 0, strobe_cyc = 0, done_cyc = 0, req_cyc = 0;
   int n_done_st = 0, n_done_ld = 0, n_done_pc = 0, n_done_tot = 0;
   int seen_st = 0, seen_ld = 0, seen_pc = 0;
   int done_log[$];
   bit saw_burst = 0;

   // Responder emulation
   int           resp_lat = 0, resp_cnt = 0;
   bit           resp_pend = 0;
   logic [63:0]  resp_ld_data = '0;
   logic [511:0] resp_pc_data = '0;

   // Reference model: owner 0 none / 1 store / 2 load / 3 pc; phase 0 idle, 1 strobe, 2 waiting, 3 responding
   bit            m_started = 0;
   int            m_owner = 0, m_phase = 0, m_wcnt = 0;
   logic          e_ce, e_busy, e_st_done, e_ld_done, e_pc_done, e_err, e_we, e_burst;
   logic [IW-1:0] e_idx;
   logic [63:0]   e_mask, e_data, e_ld_rdata;
   logic [511:0]  e_pc_rdata;
   bit            e_chk_addr = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_started = 1; m_owner = 0; m_phase = 0; m_wcnt = 0;
         e_ce = 0; e_busy = 0; e_st_done = 0; e_ld_done = 0; e_pc_done = 0; e_err = 0;
         e_we = 0; e_burst = 0; e_idx = '0; e_mask = '0; e_data = '0;
         e_ld_rdata = '0; e_pc_rdata = '0; e_chk_addr = 1;
      end else if (m_started) begin
         case (m_phase)
            0: begin
               e_ce = 0; e_busy = 0; e_chk_addr = 0;
               e_st_done = 0; e_ld_done = 0; e_pc_done = 0;
               if (ddr_ready && (opstore_req || opload_req || pc_req)) begin
                  m_owner = opstore_req ? 1 : (opload_req ? 2 : 3);
                  e_idx   = (m_owner == 1) ? opstore_index : ((m_owner == 2) ? opload_index : pc_index);
                  e_we    = (m_owner == 1);
                  e_burst = (m_owner == 3);
                  e_mask  = (m_owner == 1) ? opstore_wmask : 64'h0;
                  e_data  = (m_owner == 1) ? opstore_wdata : 64'h0;
                  e_ce = 1; e_busy = 1; e_chk_addr = 1; m_phase = 1;
               end
            end
            1: begin
               e_ce = 0; m_phase = 2; m_wcnt = 0;
            end
            2: begin
               if (ddr_operation_done) begin
                  m_phase = 3; e_chk_addr = 0;
                  e_st_done = (m_owner == 1); e_ld_done = (m_owner == 2); e_pc_done = (m_owner == 3);
                  if (m_owner == 2) e_ld_rdata = ddr_opload_read_data;
                  if (m_owner == 3) e_pc_rdata = ddr_pc_read_inst;
               end else begin
                  m_wcnt++;
`ifdef DDR_ARB_TIMEOUT_EN
                  if (m_wcnt == TMO) begin
                     m_phase = 3; e_chk_addr = 0; e_err = 1;
                     e_st_done = (m_owner == 1); e_ld_done = (m_owner == 2); e_pc_done = (m_owner == 3);
                  end
`endif
               end
            end
            default: begin
               e_st_done = 0; e_ld_done = 0; e_pc_done = 0;
               e_busy = 0; m_owner = 0; m_phase = 0;
            end
         endcase
      end
   endtask

   // One clock: check and log at the falling edge, then drive responder/requesters after the rising edge.
   task automatic tick();
      @(negedge clock);
      cyc++;
      if (m_started) begin
         chk("chip_enable", ddr_chip_enable, e_ce);
         chk("busy", busy, e_busy);
         chk("opstore_done", opstore_done, e_st_done);
         chk("opload_done", opload_done, e_ld_done);
         chk("pc_done", pc_done, e_pc_done);
         chk("opload_rdata", opload_rdata, e_ld_rdata);
         chk("pc_rdata", pc_rdata, e_pc_rdata);
         chk("timeout_err", timeout_err, e_err);
         if (e_chk_addr) begin
            chk("ddr_index", ddr_index, e_idx);
            chk("write_enable", ddr_write_enable, e_we);
            chk("burst_mode", ddr_burst_mode, e_burst);
            chk("write_mask", ddr_opstore_write_mask, e_mask);
            chk("write_data", ddr_opstore_write_data, e_data);
         end
      end
      if (ddr_chip_enable === 1'b1) begin
         n_strobe++; strobe_cyc = cyc;
         if (ddr_burst_mode === 1'b1) saw_burst = 1;
      end
      if (opstore_done === 1'b1) begin n_done_st++; n_done_tot++; done_log.push_back(1); done_cyc = cyc; end
      if (opload_done === 1'b1)  begin n_done_ld++; n_done_tot++; done_log.push_back(2); done_cyc = cyc; end
      if (pc_done === 1'b1)      begin n_done_pc++; n_done_tot++; done_log.push_back(3); done_cyc = cyc; end
      model_step();
      @(posedge clock);
      #1;
      ddr_operation_done   = 1'b0;
      ddr_opload_read_data = '0;
      ddr_pc_read_inst     = '0;
      if (resp_pend) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            ddr_operation_done   = 1'b1;
            ddr_opload_read_data = resp_ld_data;
            ddr_pc_read_inst     = resp_pc_data;
            resp_pend = 0;
         end
      end
      if (ddr_chip_enable === 1'b1 && resp_lat > 0) begin
         resp_pend = 1; resp_cnt = resp_lat;
      end
      if (n_done_st != seen_st) begin opstore_req = 1'b0; seen_st = n_done_st; end
      if (n_done_ld != seen_ld) begin opload_req = 1'b0;  seen_ld = n_done_ld; end
      if (n_done_pc != seen_pc) begin pc_req = 1'b0;      seen_pc = n_done_pc; end
   endtask

   task automatic wait_done(input int target, input string nm);
      int k = 0;
      while (n_done_tot < target && k < 300) begin
         tick();
         k++;
      end
      chk(nm, n_done_tot, target);
   endtask

   initial begin
      reset = 1'b1; ddr_ready = 1'b1;
      pc_req = 1'b0; opload_req = 1'b0; opstore_req = 1'b0;
      pc_index = '0; opload_index = '0; opstore_index = '0;
      opstore_wmask = '0; opstore_wdata = '0;
      ddr_operation_done = 1'b0; ddr_opload_read_data = '0; ddr_pc_read_inst = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_index", ddr_index, 0);
      chk("rst_pc_rdata", pc_rdata, 0);

      // Single load
      resp_lat = 3; resp_ld_data = 64'hDEADBEEF_CAFEF00D;
      opload_index = 19'h00010; opload_req = 1'b1; req_cyc = cyc + 1;
      wait_done(1, "load_done_count");
      chk("load_issue_latency", strobe_cyc - req_cyc, 1);
      chk("load_done_latency", done_cyc - strobe_cyc, 4);
      chk("load_rdata_literal", opload_rdata, 64'hDEADBEEFCAFEF00D);
      chk("load_strobes", n_strobe, 1);
      repeat (2) tick();

      // Masked store
      resp_lat = 4;
      opstore_index = 19'h7FFFF; opstore_wmask = 64'h00000000FFFFFFFF; opstore_wdata = 64'h1122334455667788;
      opstore_req = 1'b1;
      wait_done(2, "store_done_count");
      chk("store_done_pulses", n_done_st, 1);
      chk("store_keeps_load_rdata", opload_rdata, 64'hDEADBEEFCAFEF00D);
      chk("store_strobes", n_strobe, 2);
      repeat (2) tick();

      // Three simultaneous requests
      resp_lat = 2; resp_ld_data = 64'h0102030405060708; resp_pc_data = {16{32'h600DF00D}};
      opstore_index = 19'h00123; opstore_wmask = 64'hFFFF0000FFFF0000; opstore_wdata = 64'hA5A5A5A55A5A5A5A;
      opload_index = 19'h00456; pc_index = 19'h00789;
      opstore_req = 1'b1; opload_req = 1'b1; pc_req = 1'b1;
      wait_done(5, "prio_done_count");
      chk("prio_first_store", done_log[2], 1);
      chk("prio_second_load", done_log[3], 2);
      chk("prio_third_pc", done_log[4], 3);
      chk("prio_strobes", n_strobe, 5);
      chk("prio_load_rdata", opload_rdata, 64'h0102030405060708);
      repeat (2) tick();

      // Burst fetch held off by ddr_ready
      saw_burst = 0; ddr_ready = 1'b0;
      resp_lat = 5; resp_pc_data = {8{64'h0F1E2D3C4B5A6978}};
      pc_index = 19'h3ABCD; pc_req = 1'b1;
      repeat (5) tick();
      chk("burst_no_strobe_while_not_ready", n_strobe, 5);
      ddr_ready = 1'b1;
      wait_done(6, "burst_done_count");
      chk("burst_pc_rdata", pc_rdata, {8{64'h0F1E2D3C4B5A6978}});
      chk("burst_mode_seen", saw_burst, 1);
      chk("burst_strobes", n_strobe, 6);
      repeat (2) tick();

      // Reset while a load is in WAIT; the responder still answers later
      resp_lat = 6; resp_ld_data = 64'hFFFF0000FFFF0000;
      opload_index = 19'h00ABC; opload_req = 1'b1;
      repeat (3) tick();
      reset = 1'b1; opload_req = 1'b0;
      tick();
      reset = 1'b0;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_chip_enable", ddr_chip_enable, 0);
      chk("rst_mid_index", ddr_index, 0);
      chk("rst_mid_load_rdata", opload_rdata, 0);
      repeat (8) tick();
      chk("rst_mid_no_load_done", n_done_ld, 2);
      chk("rst_mid_no_reissue", n_strobe, 7);

`ifdef DDR_ARB_TIMEOUT_EN
      // Responder never answers
      resp_lat = 0;
      opload_index = 19'h00055; opload_req = 1'b1;
      wait_done(7, "tmo_done_count");
      chk("tmo_done_latency", done_cyc - strobe_cyc, TMO + 1);
      chk("tmo_err_set", timeout_err, 1);
      chk("tmo_rdata_unchanged", opload_rdata, 0);
      repeat (4) tick();
      chk("tmo_err_sticky", timeout_err, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("tmo_err_cleared", timeout_err, 0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ddr_channel_arbiter.md
Name: ddr_channel_arbiter

Overview:
- Initiator-side front end of the core-to-DDR interface.
- Accepts three independent requester channels from the core: instruction fetch (pc, 512-bit burst read), load (opload, 64-bit read) and store (opstore, 64-bit masked write).
- Serialises them onto the single DDR request bus consumed by simddr, one outstanding operation at a time.
- Returns read data and a one-cycle completion pulse to the channel that owns the operation.

Parameters:
- INDEX_W, 19, DDR index width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with DDR_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc_req  in  1  fetch request; held high until pc_done
- pc_index  in  INDEX_W  fetch line index
- pc_done  out  1  one-cycle completion pulse
- pc_rdata  out  512  fetched line
- opload_req  in  1  load request; held until opload_done
- opload_index  in  INDEX_W  load index
- opload_done  out  1  completion pulse
- opload_rdata  out  64  load data
- opstore_req  in  1  store request; held until opstore_done
- opstore_index  in  INDEX_W  store index
- opstore_wmask  in  64  bit write mask
- opstore_wdata  in  64  write data
- opstore_done  out  1  completion pulse
- ddr_chip_enable  out  1  one-cycle issue strobe
- ddr_index  out  INDEX_W  operation index
- ddr_write_enable  out  1  1 = write
- ddr_burst_mode  out  1  1 = 512-bit burst (pc)
- ddr_opstore_write_mask  out  64  store mask
- ddr_opstore_write_data  out  64  store data
- ddr_opload_read_data  in  64  load data from DDR
- ddr_pc_read_inst  in  512  burst data from DDR
- ddr_operation_done  in  1  responder completion
- ddr_ready  in  1  responder can accept an issue
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag (0 when feature absent)

Behaviour:
- Reset (synchronous, active-high): all outputs 0, rdata registers 0, state IDLE.
- Reset mid-operation: the in-flight operation is dropped and no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if ddr_ready and any req is high, grant by fixed priority opstore > opload > pc.
  - Latch grant, index, mask and data; go to ISSUE.
  - If ddr_ready is low, stay in IDLE and issue nothing.
- ISSUE (exactly one cycle): ddr_chip_enable=1.
  - ddr_write_enable=1 only for opstore; ddr_burst_mode=1 only for pc.
  - Next state is WAIT.
  - ddr_operation_done seen in ISSUE is ignored (responder minimum latency is 1 cycle after the strobe).
- WAIT: ddr_chip_enable=0.
  - ddr_index, ddr_write_enable, ddr_burst_mode, mask and data are held stable from ISSUE until leaving WAIT.
  - On ddr_operation_done: capture ddr_pc_read_inst (pc grant) or ddr_opload_read_data (opload grant); go to RESP.
- RESP (one cycle): the granted channel's done=1 and its rdata is valid; then go to IDLE.
  - For mask/data outputs, non-store grants drive 0.
- rdata outputs hold their value until the next completion on the same channel.
- Latency: req seen in IDLE at cycle 0 -> chip_enable cycle 1 -> done input at cycle N≥2 -> channel done at N+1 -> IDLE at N+2.
  - Back-to-back issue is therefore possible at N+3.
- Requesters drop req on the cycle after their done.
  - A req still high in IDLE is treated as a new request.
- Simultaneous requests: the winner is served; losers keep req high and are served in subsequent IDLE visits, store first.
- Spurious ddr_operation_done in IDLE or RESP is ignored.

Optional Feature:
- Macro: DDR_ARB_TIMEOUT_EN.
- When defined: a counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ddr_operation_done: set timeout_err (sticky until reset), pulse the granted channel's done with rdata unchanged, and return to IDLE.
- When undefined: no counter, timeout_err tied 0, WAIT waits indefinitely.

Test Plan:
- Single load: opload_req=1, idx=0x00010; responder done 3 cycles after the strobe with data 0xDEADBEEF_CAFEF00D -> one chip_enable pulse with we=0, burst=0; opload_done one cycle later; opload_rdata=0xDEADBEEFCAFEF00D.
- Store: idx=0x7FFFF, mask=0x00000000FFFFFFFF, data=0x1122334455667788 -> strobe with we=1; mask/data/index stable through WAIT; opstore_done after done; no rdata change.
- Priority: pc, opload and opstore asserted in the same cycle -> issue order store, load, pc; exactly three strobes; each done pulses once, in that order.
- Burst fetch: pc_req with ddr_ready low for 5 cycles -> no strobe until ready=1; then burst=1; pc_rdata equals the 512-bit pattern driven by the responder.
- Reset mid-WAIT: assert reset during an outstanding load -> next cycle all outputs 0 and state IDLE; no opload_done; a later done input is ignored.
- With DDR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: responder never answers -> done pulse after 8 WAIT cycles; timeout_err=1 and stays 1 until reset.
